// File: rtl/vga_capture.sv
// Captures a VGA source that shares the pixel clock, tracks its sync timing and
// issues framebuffer writes only after a full frame of correct timing has been seen.
module vga_capture #(
    parameter int H_BACK   = 45,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_BACK   = 32,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic [2:0] RIN,
    input  logic [2:0] GIN,
    input  logic [1:0] BIN,
    output logic       WE,
    output logic [9:0] ROW,
    output logic [9:0] COLUMN,
    output logic [7:0] WDATA,
    output logic       FRAME_START,
    output logic       LOCKED,
    output logic [7:0] ERR_CNT
);
    typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

    localparam logic [9:0] H_FIRST = 10'(H_BACK);
    localparam logic [9:0] H_LAST  = 10'(H_BACK + H_ACTIVE - 1);
    localparam logic [9:0] H_END   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_FIRST = 10'(V_BACK);
    localparam logic [9:0] V_LAST  = 10'(V_BACK + V_ACTIVE - 1);
    localparam logic [9:0] V_LINES = 10'(V_TOTAL);
    localparam logic [9:0] CNT_MAX = 10'd1023;

    state_t     state_q;
    logic       hs_q, vs_q, hs_prev_q, vs_prev_q, skip_q;
    logic [7:0] pix_q;
    logic [9:0] hcnt_q, vline_q;
    logic       we_q, fs_q, locked_q;
    logic [9:0] row_q, col_q;
    logic [7:0] wdata_q, err_cnt_q;

    logic       hrise, vrise, line_err, frame_err, err, active;
    logic [9:0] hcnt_d, vline_pre, vline_d;
    logic [7:0] err_cnt_d;

    always_comb begin
        hrise     = hs_q & ~hs_prev_q;
        vrise     = vs_q & ~vs_prev_q;
        hcnt_d    = hrise ? '0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1);
        // Frame length is judged on the line count after any coincident HSYNC increment.
        vline_pre = (hrise && vline_q != CNT_MAX) ? vline_q + 10'd1 : vline_q;
        vline_d   = vrise ? '0 : vline_pre;
        line_err  = (state_q == ST_LOCKED || (state_q == ST_CHECK && !skip_q))
                    && hrise && (hcnt_q != H_END);
        frame_err = (state_q != ST_SEARCH) && vrise && (vline_pre != V_LINES);
        err       = line_err | frame_err;
        active    = (state_q == ST_LOCKED)
                    && (hcnt_q >= H_FIRST) && (hcnt_q <= H_LAST)
                    && (vline_q >= V_FIRST) && (vline_q <= V_LAST);
        err_cnt_d = (state_q == ST_LOCKED && err && err_cnt_q != 8'hFF)
                    ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_SEARCH;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            skip_q    <= 1'b0;
            pix_q     <= '0;
            hcnt_q    <= '0;
            vline_q   <= '0;
            we_q      <= 1'b0;
            fs_q      <= 1'b0;
            locked_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            hs_q      <= HSYNC;
            vs_q      <= VSYNC;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            pix_q     <= {RIN, GIN, BIN};
            hcnt_q    <= hcnt_d;
            vline_q   <= vline_d;
            err_cnt_q <= err_cnt_d;
            locked_q  <= (state_q == ST_LOCKED);
            we_q      <= active & ~err;
            fs_q      <= active & ~err & (hcnt_q == H_FIRST) & (vline_q == V_FIRST);
            if (active && !err) begin
                row_q   <= vline_q - V_FIRST;
                col_q   <= hcnt_q - H_FIRST;
                wdata_q <= pix_q;
            end
            // The first HSYNC rise after entering CHECK closes a line of unknown start.
            case (state_q)
                ST_SEARCH: begin
                    if (vrise) begin
                        state_q <= ST_CHECK;
                        skip_q  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (err) begin
                        state_q <= ST_SEARCH;
                    end else begin
                        if (vrise) state_q <= ST_LOCKED;
                        if (hrise) skip_q <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (err) state_q <= ST_SEARCH;
                end
                default: state_q <= ST_SEARCH;
            endcase
        end
    end

    assign WE          = we_q;
    assign ROW         = row_q;
    assign COLUMN      = col_q;
    assign WDATA       = wdata_q;
    assign FRAME_START = fs_q;
    assign LOCKED      = locked_q;
    assign ERR_CNT     = err_cnt_q;
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture with a shrunken raster so many frames fit in a short run;
// a behavioural model built from the sync/lock rules predicts every output.
module tb_vga_capture;
    localparam int TB_HB = 2;
    localparam int TB_HA = 4;
    localparam int TB_HT = 8;
    localparam int TB_VB = 1;
    localparam int TB_VA = 3;
    localparam int TB_VT = 6;
    localparam int MARK_POS = TB_HB + 2;
    localparam int M_SEARCH = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst_n, hsync, vsync;
    logic [2:0] rin, gin;
    logic [1:0] bin;
    logic       we, frame_start, locked;
    logic [9:0] row, column;
    logic [7:0] wdata, err_cnt;

    vga_capture #(
        .H_BACK(TB_HB), .H_ACTIVE(TB_HA), .H_TOTAL(TB_HT),
        .V_BACK(TB_VB), .V_ACTIVE(TB_VA), .V_TOTAL(TB_VT)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .HSYNC(hsync), .VSYNC(vsync),
        .RIN(rin), .GIN(gin), .BIN(bin),
        .WE(we), .ROW(row), .COLUMN(column), .WDATA(wdata),
        .FRAME_START(frame_start), .LOCKED(locked), .ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int probe_cyc = -1;
    int we_cnt = 0;
    int fs_cnt = 0;
    bit rst_hold = 1'b1;
    logic [27:0] exp_q[$];

    // Reference model state: sampled syncs, counters as plain integers, lock mode.
    bit m_hs, m_vs, m_hsp, m_vsp, m_skip, m_we, m_fs, m_locked;
    int m_rgb, m_h, m_v, m_mode, m_row, m_col, m_wdata, m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_hs = 1; m_vs = 1; m_hsp = 1; m_vsp = 1; m_rgb = 0;
        m_h = 0; m_v = 0; m_mode = M_SEARCH; m_skip = 0;
        m_we = 0; m_fs = 0; m_locked = 0; m_row = 0; m_col = 0; m_wdata = 0; m_err = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit hs, input bit vs, input int rgb);
        bit hrise, vrise, line_err, frame_err, err, active;
        int v_pre;
        hrise = m_hs && !m_hsp;
        vrise = m_vs && !m_vsp;
        v_pre = hrise ? ((m_v + 1 > 1023) ? 1023 : m_v + 1) : m_v;
        line_err = hrise && (m_mode == M_LOCKED || (m_mode == M_CHECK && !m_skip))
                   && (m_h != TB_HT - 1);
        frame_err = vrise && (m_mode != M_SEARCH) && (v_pre != TB_VT);
        err = line_err || frame_err;
        active = (m_mode == M_LOCKED) && m_h >= TB_HB && m_h < TB_HB + TB_HA
                 && m_v >= TB_VB && m_v < TB_VB + TB_VA;
        m_we = active && !err;
        m_fs = 0;
        if (m_we) begin
            m_row = m_v - TB_VB;
            m_col = m_h - TB_HB;
            m_wdata = m_rgb;
            m_fs = (m_row == 0) && (m_col == 0);
            exp_q.push_back({10'(m_row), 10'(m_col), 8'(m_wdata)});
        end
        m_locked = (m_mode == M_LOCKED);
        if (m_mode == M_LOCKED && err && m_err < 255) m_err++;
        if (m_mode == M_SEARCH) begin
            if (vrise) begin m_mode = M_CHECK; m_skip = 1; end
        end else if (m_mode == M_CHECK) begin
            if (err) m_mode = M_SEARCH;
            else begin
                if (vrise) m_mode = M_LOCKED;
                if (hrise) m_skip = 0;
            end
        end else if (err) begin
            m_mode = M_SEARCH;
        end
        m_h = hrise ? 0 : ((m_h + 1 > 1023) ? 1023 : m_h + 1);
        m_v = vrise ? 0 : v_pre;
        m_hsp = m_hs; m_vsp = m_vs;
        m_hs = hs; m_vs = vs; m_rgb = rgb;
    endfunction

    task automatic drive(input bit hs, input bit vs, input logic [7:0] rgb, input bit mark);
        logic [27:0] e;
        @(negedge clk);
        rst_n = !rst_hold;
        hsync = hs;
        vsync = vs;
        {rin, gin, bin} = rgb;
        if (mark) probe_cyc = cyc + 1;
        @(posedge clk);
        if (rst_n) model_step(hs, vs, int'(rgb));
        else model_reset();
        #1;
        check("we", 32'(we), 32'(m_we));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("locked", 32'(locked), 32'(m_locked));
        check("err_cnt", 32'(err_cnt), m_err);
        if (we) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("write_payload", 32'({row, column, wdata}), 32'(e));
            we_cnt++;
        end else begin
            check("hold_row", 32'(row), m_row);
            check("hold_col", 32'(column), m_col);
            check("hold_wdata", 32'(wdata), m_wdata);
        end
        if (frame_start) fs_cnt++;
        if (cyc == probe_cyc) begin
            check("probe_we", 32'(we), 32'd1);
            check("probe_row", 32'(row), 32'd2);
            check("probe_col", 32'(column), 32'd1);
            check("probe_wdata", 32'(wdata), 32'hA5);
        end
        cyc++;
    endtask

    task automatic send_line(input int len, input bit vs_low, input int mark_pos);
        for (int pos = 0; pos < len; pos++)
            drive(pos != len - 1, !vs_low,
                  (pos == mark_pos) ? 8'hA5 : 8'($urandom_range(0, 255)), pos == mark_pos);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input int mark_line);
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_line) ? bad_len : TB_HT, l == nlines - 1,
                      (l == mark_line) ? MARK_POS : -1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_we", 32'(we), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_row", 32'(row), 32'd0);
        check("rst_col", 32'(column), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        rst_hold = 1'b1;
        repeat (2) drive(1'b1, 1'b1, 8'h00, 1'b0);
        rst_hold = 1'b0;
    endtask

    task automatic lock_up();
        send_line(TB_HT, 1'b1, -1);
        send_frame(TB_VT, -1, 0, -1);
        send_frame(TB_VT, -1, 0, -1);
    endtask

    initial begin
        rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; rin = '0; gin = '0; bin = '0;
        model_reset();
        repeat (2) drive(1'b1, 1'b1, 8'h00, 1'b0);
        reset_dut();

        // Nominal: lock after the second VSYNC rise, full third frame, probed pixel.
        send_line(TB_HT, 1'b1, -1);
        send_frame(TB_VT, -1, 0, -1);
        check("a_locked_after_f1", 32'(locked), 32'd0);
        send_frame(TB_VT, -1, 0, -1);
        check("a_locked_after_f2", 32'(locked), 32'd1);
        we_cnt = 0; fs_cnt = 0;
        send_frame(TB_VT, -1, 0, TB_VB + 2);
        check("a_f3_writes", we_cnt, TB_HA * TB_VA);
        check("a_f3_frame_starts", fs_cnt, 1);

        // One overlong line while locked.
        reset_dut();
        lock_up();
        send_frame(TB_VT, 2, TB_HT + 1, -1);
        check("b_err_cnt", 32'(err_cnt), 32'd1);
        check("b_unlocked", 32'(locked), 32'd0);
        we_cnt = 0;
        send_frame(TB_VT, -1, 0, -1);
        check("b_no_writes_relock", we_cnt, 0);
        check("b_still_unlocked", 32'(locked), 32'd0);
        we_cnt = 0;
        send_frame(TB_VT, -1, 0, -1);
        check("b_relocked", 32'(locked), 32'd1);
        check("b_writes_after_relock", we_cnt, TB_HA * TB_VA);

        // Frame one line short while locked.
        reset_dut();
        lock_up();
        send_frame(TB_VT - 1, -1, 0, -1);
        send_line(TB_HT, 1'b0, -1);
        check("c_err_cnt", 32'(err_cnt), 32'd1);
        check("c_unlocked", 32'(locked), 32'd0);

        // Reset in the middle of a locked frame.
        reset_dut();
        lock_up();
        for (int l = 0; l < 3; l++) send_line(TB_HT, 1'b0, -1);
        reset_dut();
        for (int l = 3; l < TB_VT; l++) send_line(TB_HT, l == TB_VT - 1, -1);
        send_frame(TB_VT, -1, 0, -1);
        check("d_not_yet_locked", 32'(locked), 32'd0);
        send_line(TB_HT, 1'b0, -1);
        check("d_relocked", 32'(locked), 32'd1);
        check("d_err_cnt", 32'(err_cnt), 32'd0);

        // Bad frames: uncounted while checking, counted and saturating while locked.
        reset_dut();
        send_line(TB_HT, 1'b1, -1);
        repeat (40) send_frame(TB_VT, 1, TB_HT - 1, -1);
        check("e_check_errs_uncounted", 32'(err_cnt), 32'd0);
        send_frame(TB_VT, -1, 0, -1);
        repeat (200) begin
            send_frame(TB_VT, 1, TB_HT - 1, -1);
            send_frame(TB_VT, -1, 0, -1);
        end
        check("e_err_cnt_200", 32'(err_cnt), 32'd200);
        repeat (60) begin
            send_frame(TB_VT, 1, TB_HT - 1, -1);
            send_frame(TB_VT, -1, 0, -1);
        end
        check("e_err_cnt_saturated", 32'(err_cnt), 32'd255);

        // HSYNC stuck low while locked.
        reset_dut();
        lock_up();
        send_line(TB_HT, 1'b0, -1);
        send_line(TB_HT, 1'b0, -1);
        we_cnt = 0;
        repeat (2000) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        check("f_no_writes_stall", we_cnt, 0);
        check("f_no_err_during_stall", 32'(err_cnt), 32'd0);
        for (int l = 2; l < TB_VT; l++) send_line(TB_HT, l == TB_VT - 1, -1);
        check("f_single_err", 32'(err_cnt), 32'd1);
        check("f_unlocked", 32'(locked), 32'd0);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
